div_norm: RTL and testbench
===========================

# div_norm

Sequential unsigned divider that brings the bicubic weighted-sum products back down to pixel range. Each transaction divides a wide accumulated product by the weight sum, rounds, and saturates to an output pixel. It sits after the weight-multiply/accumulate stage and before the pixel output register. It uses an iterative radix-2 restoring algorithm with valid/ready handshakes on both sides.

## Interface
- DW, 38, dividend width (accumulated weighted sum)
- VW, 20, divisor width (weight sum)
- OW, 8, output pixel width
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  dividend/divisor present
- in_ready  out  1  block can accept; high only in IDLE
- dividend  in  DW  unsigned numerator
- divisor  in  VW  unsigned denominator
- out_valid  out  1  result valid; held until taken
- out_ready  in  1  downstream accepts result
- quotient  out  OW  rounded, saturated result
- sat  out  1  full quotient exceeded 2^OW-1, or divide-by-zero
- dz  out  1  divisor was zero

## Operation
- Clocking and reset: one clock, clk. Reset is asynchronous, active-low, on rst_n.
- Reset values:
  - state=IDLE, in_ready=1, out_valid=0.
  - quotient=0, sat=0, dz=0.
  - internal remainder, quotient and counter registers are all 0.
- FSM states: IDLE, CALC, ROUND, DONE.
- IDLE: in_ready=1. On in_valid&in_ready, the block captures the operands.
  - Quotient shift register is loaded with dividend.
  - Remainder register (VW+1 bits) is loaded with 0.
  - Counter is loaded with DW-1, and the FSM goes to CALC.
- CALC: one restoring step per cycle.
  - Form trial value t = {rem[VW-1:0], q[DW-1]} - {1'b0, divisor}.
  - If t is non-negative: rem=t and shift 1 into q.
  - Otherwise: rem={rem[VW-1:0], q[DW-1]} and shift 0 into q.
  - After the step where counter=0, the FSM goes to ROUND. CALC therefore lasts exactly DW cycles.
- ROUND (with DIV_ROUND_EN): if 2*rem >= divisor, q_full = q+1 (DW+1 bits); otherwise q_full = q.
- Saturation in ROUND:
  - If q_full > 2^OW-1: quotient=all-ones and sat=1.
  - Otherwise: quotient=q_full[OW-1:0] and sat=0.
- Divide-by-zero: a zero divisor is latched at capture.
  - In ROUND the block forces quotient=all-ones, sat=1, dz=1.
  - Latency is identical to a normal division; no early exit.
- ROUND sets out_valid=1 and moves to DONE.
- DONE:
  - quotient, sat and dz stay stable while out_valid=1.
  - On out_ready, out_valid drops and the FSM returns to IDLE.
- No new input is accepted in CALC, ROUND or DONE; in_ready=0 in those states.
- quotient, sat and dz keep their last values after the handshake, until the next ROUND.

## Timing
- Accept edge E0 is the first edge with in_valid&in_ready.
- CALC occupies edges E1..E_DW. ROUND is edge E_DW+1, and out_valid is high after that edge.
- Latency is DW+1 cycles from accept to out_valid (39 at defaults).
- Throughput, with out_ready tied high:
  - out_valid drops at E_DW+2, and in_ready is high again after that edge.
  - The next accept can occur at E_DW+3, so the block sustains one result per DW+3 cycles.
- Backpressure: out_valid remains 1 and outputs remain stable for any number of cycles with out_ready=0.
- in_valid asserted outside IDLE is ignored. The source must hold its data until in_ready is seen.
- Reset mid-operation (any state): the block returns to IDLE immediately.
  - out_valid=0, in_ready=1, and the partial result is discarded.
  - No out_valid pulse is produced for the aborted operation.
- The counter never wraps; its terminal value of 0 is the only exit from CALC.

## Configuration
- Macro: DIV_ROUND_EN.
- Defined: round-half-up as described in ROUND, with an extra rem compare and an incrementer.
- Not defined: truncation, q_full = q. The ROUND state is still present, so latency is unchanged. Saturation and dz behaviour are unchanged.

## Test plan
- Exact division: dividend=1000, divisor=10, out_ready=1.
  - Required: quotient=100, sat=0, dz=0, out_valid exactly 39 cycles after accept.
- Rounding: dividend=1005, divisor=10.
  - With DIV_ROUND_EN: quotient=101.
  - Without DIV_ROUND_EN: quotient=100.
  - dividend=1004 gives quotient=100 in both builds.
- Saturation: dividend=5000, divisor=10.
  - Required: quotient=255, sat=1, dz=0.
  - dividend=2^38-1, divisor=1 also gives quotient=255, sat=1.
- Divide-by-zero: dividend=123, divisor=0.
  - Required: quotient=255, sat=1, dz=1, same 39-cycle latency.
- Backpressure and back-to-back:
  - Hold out_ready=0 for 5 cycles after out_valid. Required: quotient stable, in_ready=0 throughout.
  - Hold in_valid high with a second operand pair. Required: it is accepted only after the DONE handshake.
- Reset mid-CALC: pulse rst_n low at cycle 20 of CALC.
  - Required: out_valid=0, in_ready=1, quotient=0 immediately.
  - A subsequent 1000/10 returns 100.

Source files
------------

// File: rtl/div_norm.sv
// -----------------------------------------------------------------------------
// div_norm
//
// Sequential unsigned divider that scales bicubic weighted-sum products back
// to pixel range.  Each transaction computes dividend / divisor with a radix-2
// restoring algorithm (one quotient bit per cycle), optionally rounds
// half-up, then saturates to an OW-bit pixel.
//
// Build option:
//   DIV_ROUND_EN  defined     -> round-half-up (q + 1 when 2*rem >= divisor)
//                 not defined -> truncation.  The ROUND cycle is kept, so
//                                latency is the same in both builds.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   dividend/divisor present
//   in_ready   block can accept (high only in IDLE)
//   dividend   DW-bit unsigned numerator
//   divisor    VW-bit unsigned denominator
//   out_valid  result valid, held until out_ready
//   out_ready  downstream accepts result
//   quotient   OW-bit rounded, saturated result
//   sat        quotient overflowed 2^OW-1, or divide-by-zero
//   dz         divisor was zero
//
// Timing: accept at E0, CALC on E1..E_DW, ROUND on E_DW+1, out_valid high
// after that edge (DW+1 cycles of latency).
// -----------------------------------------------------------------------------
module div_norm #(
    parameter int DW = 38,
    parameter int VW = 20,
    parameter int OW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [OW-1:0] quotient,
    output logic          sat,
    output logic          dz
);

    localparam int CW = (DW > 1) ? $clog2(DW) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(DW - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        state_q;
    state_t        state_d;

    logic [VW:0]   rem_q;
    logic [DW-1:0] q_q;
    logic [CW-1:0] cnt_q;
    logic [VW-1:0] div_q;
    logic          dz_lat_q;

    logic [OW-1:0] quotient_q;
    logic          sat_q;
    logic          dz_q;

    // Restoring step datapath
    logic [VW+1:0] shifted;
    logic [VW:0]   diff;
    logic          step_neg;
    logic [VW:0]   step_rem;

    logic [DW:0]   q_full;
    logic [OW:0]   sat_res;

`ifdef DIV_ROUND_EN
    // Round half up: bump the quotient when the remainder is at least half
    // the divisor.  Result is one bit wider so the carry is never lost.
    function automatic logic [DW:0] round_q(
        input logic [DW-1:0] q,
        input logic [VW:0]   rem,
        input logic [VW-1:0] dv
    );
        if ({rem, 1'b0} >= {2'b00, dv}) begin
            return {1'b0, q} + (DW+1)'(1);
        end
        return {1'b0, q};
    endfunction
`else
    function automatic logic [DW:0] round_q(
        input logic [DW-1:0] q
    );
        return {1'b0, q};
    endfunction
`endif

    // Returns {sat, quotient}.  A zero divisor always forces full scale.
    function automatic logic [OW:0] saturate(
        input logic [DW:0] qf,
        input logic        zero_div
    );
        logic over;
        over = |qf[DW:OW];
        if (zero_div || over) begin
            return {1'b1, {OW{1'b1}}};
        end
        return {1'b0, qf[OW-1:0]};
    endfunction

    // The remainder always stays below the divisor, so its top bit is zero
    // here and the shifted value fits in VW+1 bits; the compare still uses
    // the full width so no bit is silently dropped.
    always_comb begin
        shifted  = {rem_q, q_q[DW-1]};
        step_neg = (shifted < {2'b00, div_q});
        diff     = shifted[VW:0] - {1'b0, div_q};
        step_rem = step_neg ? shifted[VW:0] : diff;
    end

    always_comb begin
`ifdef DIV_ROUND_EN
        q_full = round_q(q_q, rem_q, div_q);
`else
        q_full = round_q(q_q);
`endif
        sat_res = saturate(q_full, dz_lat_q);
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; the counter reaching zero is the only exit from CALC
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)      state_d = CALC;
            CALC:    if (cnt_q == '0)   state_d = ROUND;
            ROUND:                      state_d = DONE;
            DONE:    if (out_ready)     state_d = IDLE;
            default:                    state_d = IDLE;
        endcase
    end

    // Datapath and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q      <= '0;
            q_q        <= '0;
            cnt_q      <= '0;
            div_q      <= '0;
            dz_lat_q   <= 1'b0;
            quotient_q <= '0;
            sat_q      <= 1'b0;
            dz_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        q_q      <= dividend;
                        rem_q    <= '0;
                        cnt_q    <= CNT_INIT;
                        div_q    <= divisor;
                        dz_lat_q <= (divisor == '0);
                    end
                end
                CALC: begin
                    rem_q <= step_rem;
                    q_q   <= {q_q[DW-2:0], ~step_neg};
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ROUND: begin
                    quotient_q <= sat_res[OW-1:0];
                    sat_q      <= sat_res[OW];
                    dz_q       <= dz_lat_q;
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign quotient  = quotient_q;
    assign sat       = sat_q;
    assign dz        = dz_q;

endmodule

// File: tb/tb_div_norm.sv
// -----------------------------------------------------------------------------
// tb_div_norm: directed self-checking bench for div_norm.  Expected results
// come from a behavioural integer model and are queued when each operand pair
// is driven, then popped when the DUT raises out_valid.
// -----------------------------------------------------------------------------
module tb_div_norm;

    localparam int DW = 38;
    localparam int VW = 20;
    localparam int OW = 8;
    localparam int LAT = DW + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] dividend = '0;
    logic [VW-1:0] divisor = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [OW-1:0] quotient;
    logic          sat;
    logic          dz;

    typedef struct {
        logic [OW-1:0] q;
        logic          s;
        logic          z;
    } exp_t;

    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    div_norm #(.DW(DW), .VW(VW), .OW(OW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .sat       (sat),
        .dz        (dz)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, expv);
        end
    endtask

    function automatic exp_t model(input logic [DW-1:0] dd, input logic [VW-1:0] dv);
        exp_t e;
        longint unsigned n, d, q, r;
        n = longint'(dd);
        d = longint'(dv);
        if (d == 0) begin
            e.q = 8'hFF; e.s = 1'b1; e.z = 1'b1;
            return e;
        end
        q = n / d;
        r = n % d;
`ifdef DIV_ROUND_EN
        if (2 * r >= d) q = q + 1;
`else
        if (r > d) q = q + 1;  // never true; truncation
`endif
        if (q > 255) begin
            e.q = 8'hFF; e.s = 1'b1;
        end else begin
            e.q = q[7:0]; e.s = 1'b0;
        end
        e.z = 1'b0;
        return e;
    endfunction

    // Drive an operand pair and return once it has been accepted (#1 after E0)
    task automatic start(input string tag, input logic [DW-1:0] dd, input logic [VW-1:0] dv,
                         input bit push);
        int w;
        if (push) sb.push_back(model(dd, dv));
        dividend = dd;
        divisor  = dv;
        in_valid = 1'b1;
        w = 0;
        while (!in_ready && w < 200) begin
            @(posedge clk); #1;
            w++;
        end
        check({tag, "_accept_ready"}, in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Count cycles from accept to out_valid, then compare against the queue
    task automatic collect(input string tag);
        int   lat;
        exp_t e;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_latency"}, lat, LAT);
        check({tag, "_sb_nonempty"}, sb.size() != 0, 1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check({tag, "_quotient"}, quotient, e.q);
            check({tag, "_sat"}, sat, e.s);
            check({tag, "_dz"}, dz, e.z);
        end
    endtask

    // Take the result and confirm the block returns to IDLE on that edge
    task automatic handshake(input string tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_ov_drop"}, out_valid, 0);
        check({tag, "_ready_back"}, in_ready, 1);
    endtask

    task automatic txn(input string tag, input logic [DW-1:0] dd, input logic [VW-1:0] dv);
        start(tag, dd, dv, 1'b1);
        collect(tag);
        handshake(tag);
    endtask

    initial begin
        logic [OW-1:0] held;
        exp_t e;
        int w;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_quotient", quotient, 0);
        check("rst_sat", sat, 0);
        check("rst_dz", dz, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Exact, rounding and saturation cases
        txn("exact_1000_10", 38'd1000, 20'd10);
        txn("round_1005_10", 38'd1005, 20'd10);
        txn("round_1004_10", 38'd1004, 20'd10);
        txn("sat_5000_10", 38'd5000, 20'd10);
        txn("sat_max_1", {DW{1'b1}}, 20'd1);
        txn("dz_123_0", 38'd123, 20'd0);
        txn("round_255_1", 38'd255, 20'd1);
        txn("round_2559_10", 38'd2559, 20'd10);
        txn("big_div", 38'd250_000_000, 20'd1_000_000);

        // Backpressure with a second pair waiting on the input side
        start("bp_first", 38'd200, 20'd2, 1'b1);
        collect("bp_first");
        held = quotient;
        dividend = 38'd77;
        divisor  = 20'd7;
        in_valid = 1'b1;
        sb.push_back(model(38'd77, 20'd7));
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_hold_quotient", quotient, held);
            check("bp_hold_valid", out_valid, 1);
            check("bp_hold_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp_release_ov", out_valid, 0);
        check("bp_release_ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp_second_accepted", in_ready, 0);
        collect("bp_second");
        handshake("bp_second");

        // Reset during CALC: aborted operation must leave no trace
        start("abort", 38'd999_999, 20'd3, 1'b0);
        repeat (20) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", out_valid, 0);
        check("abort_in_ready", in_ready, 1);
        check("abort_quotient", quotient, 0);
        check("abort_sat", sat, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        w = 0;
        for (int i = 0; i < LAT + 5; i++) begin
            @(posedge clk); #1;
            if (out_valid) w++;
        end
        check("abort_no_pulse", w, 0);
        txn("after_abort_1000_10", 38'd1000, 20'd10);

        check("sb_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
